aemb2_wb_arbiter: RTL
=====================

# aemb2_wb_arbiter

Two-master, one-slave bus arbiter that shares the MWB RAM port between the CPU data bus (DWB) and the extension bus (XWB). It sits between the aeMB2 core's DWB/XWB masters and the on-chip RAM. A registered grant state machine with round-robin fairness holds the bus for one complete transaction. Optional timeout logic terminates hung transactions.

## Interface
- AEMB_DWB, 13: DWB/MWB address MSB+1; address bits [AEMB_DWB-1:2].
- AEMB_XWB, 5: XWB address MSB+1; must be ≤ AEMB_DWB.
- TMO_W, 4: timeout counter width; used only with AEMB2_ARB_TMO_EN.

Ports:
- sys_clk_i  in  1  single clock; all state changes on its rising edge.
- sys_rst_i  in  1  asynchronous, active-high reset.
- dwb_adr_o/dwb_dat_o/dwb_sel_o  in  [AEMB_DWB-1:2]/32/4  DWB master address, write data and byte select.
- dwb_stb_o, dwb_cyc_o, dwb_wre_o, dwb_tag_o  in  1 each  DWB master control.
- dwb_dat_i  out  32  read data returned to DWB.
- dwb_ack_i  out  1  acknowledge to DWB.
- xwb_adr_o/xwb_dat_o/xwb_sel_o  in  [AEMB_XWB-1:2]/32/4  XWB master address, write data and byte select.
- xwb_stb_o, xwb_cyc_o, xwb_wre_o, xwb_tag_o  in  1 each  XWB master control.
- xwb_dat_i  out  32  read data returned to XWB.
- xwb_ack_i  out  1  acknowledge to XWB.
- mwb_adr_o/mwb_dat_o/mwb_sel_o  out  [AEMB_DWB-1:2]/32/4  slave address, write data and byte select.
- mwb_stb_o, mwb_cyc_o, mwb_wre_o, mwb_tag_o  out  1 each  slave control.
- mwb_dat_i  in  32  slave read data.
- mwb_ack_i  in  1  slave acknowledge.
- arb_tmo_o  out  1  one-cycle pulse when a transaction times out.

## Operation
- Request definitions: reqD = dwb_stb_o & dwb_cyc_o; reqX = xwb_stb_o & xwb_cyc_o.
- States: IDLE, GNT_D, GNT_X. The state register is 2 bits.
- `last` is a 1-bit register holding the most recently granted master. Reset value is X, so D wins the first tie.
- IDLE transitions:
  - Only reqD → GNT_D. Only reqX → GNT_X.
  - Both → grant the master ≠ last.
  - Neither → stay in IDLE.
  - On entry to GNT_n, `last` ← n.
- GNT_n, cycle with mwb_ack_i = 1 (transaction done):
  - The other master is requesting → go directly to its grant state and update `last`.
  - Otherwise → IDLE.
  - The current master's own stb is ignored in this cycle.
- GNT_n with cyc of master n = 0 (abort) → IDLE. mwb_ack_i is not forwarded in that cycle.
- Slave output muxing, combinational from the registered state:
  - In GNT_n, all mwb_* outputs follow master n.
  - XWB address is zero-extended to AEMB_DWB-2 bits.
  - In IDLE, all mwb_* outputs are 0.
- Return path:
  - dwb_ack_i = mwb_ack_i & (state == GNT_D); xwb_ack_i is the same with GNT_X.
  - dwb_dat_i and xwb_dat_i both carry mwb_dat_i unconditionally. Masters qualify the data with their ack.
- Reset, asynchronous and mid-transaction included: state ← IDLE, last ← X, counter ← 0. All mwb_* outputs, both acks and arb_tmo_o go to 0 immediately.

## Timing
- Grant latency: a request seen in IDLE in cycle N drives mwb_stb_o = 1 in cycle N+1.
- The ack is combinational from slave to master (zero added latency).
- Back-to-back handover: if X is requesting during D's ack cycle M, X's stb reaches MWB in cycle M+1. There are no idle bubbles.
- A single master doing back-to-back transactions goes through IDLE. Minimum pitch is 1 grant cycle + slave latency + 1.
- Round-robin bound: under continuous contention, grants strictly alternate D, X, D, X.

## Configuration
- Macro: AEMB2_ARB_TMO_EN.
- Defined:
  - A TMO_W-bit counter clears on every grant entry and increments each granted cycle without an ack.
  - In the granted cycle where the counter equals 2^TMO_W−1 and mwb_ack_i = 0, the arbiter:
    - forces ack = 1 to the granted master, with its dat_i = 32'h0;
    - forces mwb_stb_o = 0;
    - pulses arb_tmo_o = 1;
    - leaves the state exactly as for a normal ack.
  - A real ack in that cycle takes precedence, and no timeout occurs.
- Undefined: no counter is built, arb_tmo_o is tied to 0, and a grant is held indefinitely until ack or abort.

## Test plan
- Reset, then DWB read of adr 0x010 with the slave acking 2 cycles later and mwb_dat_i = 32'hCAFEF00D → mwb_stb_o rises 1 cycle after the request; dwb_ack_i = 1 with dwb_dat_i = CAFEF00D; xwb_ack_i stays 0.
- reqD and reqX raised in the same cycle after reset → D is granted first. On D's ack, X is granted in the next cycle, and mwb_adr_o shows X's address zero-extended.
- Both masters requesting continuously for 8 transactions → the grant order is D, X, D, X, D, X, D, X.
- DWB drops cyc while granted and before ack; the slave acks one cycle later → state is IDLE, dwb_ack_i is never asserted, and a pending XWB request is granted.
- sys_rst_i asserted mid-grant → all mwb_* outputs are 0 in the same cycle, without waiting for a clock edge. After release, the first tie goes to D.
- With AEMB2_ARB_TMO_EN defined and TMO_W = 4, a slave that never acks → on the 16th granted cycle, dwb_ack_i = 1, dwb_dat_i = 0 and arb_tmo_o pulses once; the bus then returns to IDLE.

Source files
------------

// File: rtl/aemb2_wb_arbiter.sv
// Round-robin two-master (DWB, XWB) arbiter for the shared MWB RAM port.
// Optional hung-transaction timeout: define AEMB2_ARB_TMO_EN.
module aemb2_wb_arbiter #(
  parameter int AEMB_DWB = 13,
  parameter int AEMB_XWB = 5,
  parameter int TMO_W    = 4
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [AEMB_DWB-1:2] dwb_adr_o,
  input  logic [31:0]         dwb_dat_o,
  input  logic [3:0]          dwb_sel_o,
  input  logic                dwb_stb_o,
  input  logic                dwb_cyc_o,
  input  logic                dwb_wre_o,
  input  logic                dwb_tag_o,
  output logic [31:0]         dwb_dat_i,
  output logic                dwb_ack_i,
  input  logic [AEMB_XWB-1:2] xwb_adr_o,
  input  logic [31:0]         xwb_dat_o,
  input  logic [3:0]          xwb_sel_o,
  input  logic                xwb_stb_o,
  input  logic                xwb_cyc_o,
  input  logic                xwb_wre_o,
  input  logic                xwb_tag_o,
  output logic [31:0]         xwb_dat_i,
  output logic                xwb_ack_i,
  output logic [AEMB_DWB-1:2] mwb_adr_o,
  output logic [31:0]         mwb_dat_o,
  output logic [3:0]          mwb_sel_o,
  output logic                mwb_stb_o,
  output logic                mwb_cyc_o,
  output logic                mwb_wre_o,
  output logic                mwb_tag_o,
  input  logic [31:0]         mwb_dat_i,
  input  logic                mwb_ack_i,
  output logic                arb_tmo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_X = 2'd2
  } state_t;

  state_t state, next_state;
  logic last;
  logic req_d, req_x, abort, tmo, done;
  logic [AEMB_DWB-1:2] xwb_adr_ext;

  assign req_d = dwb_stb_o & dwb_cyc_o;
  assign req_x = xwb_stb_o & xwb_cyc_o;
  assign abort = ((state == GNT_D) & ~dwb_cyc_o) | ((state == GNT_X) & ~xwb_cyc_o);
  assign done  = (state != IDLE) & ~abort & (mwb_ack_i | tmo);

`ifdef AEMB2_ARB_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i)
      tmo_cnt <= '0;
    else if ((next_state != IDLE) && (next_state != state))
      tmo_cnt <= '0;
    else if ((state != IDLE) && !mwb_ack_i)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo = (state != IDLE) & ~abort & ~mwb_ack_i & (tmo_cnt == '1);
`else
  assign tmo = 1'b0;
`endif

  // last = 1 means XWB was granted most recently; resetting to 1 lets DWB win the first tie
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state == GNT_D)
        last <= 1'b0;
      else if (next_state == GNT_X)
        last <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_d && req_x)
          next_state = last ? GNT_D : GNT_X;
        else if (req_d)
          next_state = GNT_D;
        else if (req_x)
          next_state = GNT_X;
      end
      GNT_D: begin
        if (abort)
          next_state = IDLE;
        else if (done)
          next_state = req_x ? GNT_X : IDLE;
      end
      GNT_X: begin
        if (abort)
          next_state = IDLE;
        else if (done)
          next_state = req_d ? GNT_D : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    xwb_adr_ext = '0;
    xwb_adr_ext[AEMB_XWB-1:2] = xwb_adr_o;
  end

  always_comb begin
    mwb_adr_o = '0;
    mwb_dat_o = '0;
    mwb_sel_o = '0;
    mwb_stb_o = 1'b0;
    mwb_cyc_o = 1'b0;
    mwb_wre_o = 1'b0;
    mwb_tag_o = 1'b0;
    case (state)
      GNT_D: begin
        mwb_adr_o = dwb_adr_o;
        mwb_dat_o = dwb_dat_o;
        mwb_sel_o = dwb_sel_o;
        mwb_stb_o = dwb_stb_o & ~tmo;
        mwb_cyc_o = dwb_cyc_o;
        mwb_wre_o = dwb_wre_o;
        mwb_tag_o = dwb_tag_o;
      end
      GNT_X: begin
        mwb_adr_o = xwb_adr_ext;
        mwb_dat_o = xwb_dat_o;
        mwb_sel_o = xwb_sel_o;
        mwb_stb_o = xwb_stb_o & ~tmo;
        mwb_cyc_o = xwb_cyc_o;
        mwb_wre_o = xwb_wre_o;
        mwb_tag_o = xwb_tag_o;
      end
      default: ;
    endcase
  end

  // An aborting master gets no ack; a timed-out master sees a forced ack with zero data
  assign dwb_ack_i = (state == GNT_D) & ~abort & (mwb_ack_i | tmo);
  assign xwb_ack_i = (state == GNT_X) & ~abort & (mwb_ack_i | tmo);
  assign dwb_dat_i = (tmo && (state == GNT_D)) ? 32'h0 : mwb_dat_i;
  assign xwb_dat_i = (tmo && (state == GNT_X)) ? 32'h0 : mwb_dat_i;
  assign arb_tmo_o = tmo;

endmodule
